// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and the future receiver.
//   state_t     - 3-bit frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   LINE_IDLE   - level of an idle line and of the stop bit
//   START_BIT   - level of the start bit
//   frame_bits  - line bits per frame for a given data width
// Optional feature macro: SERIAL_TX_PARITY_EN (adds one even-parity bit per frame).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Start + data + (parity) + stop.
    function automatic int unsigned frame_bits(input int unsigned data_w);
`ifdef SERIAL_TX_PARITY_EN
        return data_w + 3;
`else
        return data_w + 2;
`endif
    endfunction

endpackage

// File: rtl/serial_baud_cnt.sv
// serial_baud_cnt: per-bit cycle counter for the serial transmitter.
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   clear    - hold the counter at zero (used while the line is idle)
//   bit_done - high on the last clk cycle of each line bit
module serial_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // With CLKS_PER_BIT == 1 the counter sits at zero and every cycle ends a bit.
    assign bit_done = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || bit_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: UART-style transmitter. Takes one word per valid/ready handshake and sends it
// LSB-first as start bit, data bits, optional even parity bit, stop bit; each line bit is
// held for CLKS_PER_BIT clk cycles.
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset; aborts any frame in flight
//   tx_data  - word to send, sampled on the accept edge only
//   tx_valid - producer has a word on tx_data
//   tx_ready - idle and able to accept
//   tx_line  - registered serial output, idles high
//   busy     - frame in progress (~tx_ready)
// Optional feature macro: SERIAL_TX_PARITY_EN (even parity bit before stop).
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy
);

    localparam int unsigned BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              line_q, line_d;
    logic              accept;
    logic              bit_done;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    serial_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .bit_done(bit_done)
    );

    assign accept   = tx_valid && (state_q == IDLE);
    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;
    assign tx_line  = line_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    bit_d    = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is a registered decode of the next state, so it changes on the same edge
    // as the state and the start bit appears the cycle after the accept edge.
    always_comb begin
        line_d = LINE_IDLE;
        case (state_d)
            IDLE:    line_d = LINE_IDLE;
            START:   line_d = START_BIT;
            DATA:    line_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  line_d = parity_d;
`endif
            STOP:    line_d = LINE_IDLE;
            default: line_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            line_q   <= LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            line_q   <= line_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed self-checking bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point,
// i.e. they show the state produced by the edge just taken.
module tb_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_line;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_line (tx_line),
        .busy    (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_line"}, tx_line, 1'b1);
        check({tag, "_ready"}, tx_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // Called in the cycle right after the accept edge. Checks every cycle of the frame,
    // then the first idle cycle. inject_at >= 0 pulses tx_valid with 0x81 at that offset.
    task automatic check_frame(input logic [DW-1:0] d, input int inject_at);
        logic [15:0] fr;
        fr    = '0;
        fr[0] = 1'b0;
        for (int i = 0; i < DW; i++) fr[1+i] = d[i];
`ifdef SERIAL_TX_PARITY_EN
        fr[DW+1] = ^d;
`endif
        fr[NB-1] = 1'b1;
        for (int j = 0; j < NB * CPB; j++) begin
            if (j == inject_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'h81;
            end else if (inject_at >= 0 && j == inject_at + 1) begin
                tx_valid = 1'b0;
            end
            check("frame_line", tx_line, fr[j/CPB]);
            check("frame_ready", tx_ready, 1'b0);
            check("frame_busy", busy, 1'b1);
            step();
        end
        check_idle("frame_end");
    endtask

    task automatic send(input logic [DW-1:0] d, input int inject_at);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check_frame(d, inject_at);
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;

        // Reset, then a long idle stretch.
        repeat (3) begin
            step();
            check_idle("reset");
        end
        rst = 1'b0;
        repeat (20) begin
            step();
            check_idle("idle");
        end

        // Single frame 0xA5.
        send(8'hA5, -1);

        // Back-to-back 0x00 then 0xFF with tx_valid held high.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hFF;
        check_frame(8'h00, -1);
        step();
        tx_valid = 1'b0;
        check_frame(8'hFF, -1);
        repeat (5) begin
            step();
            check_idle("b2b_after");
        end

        // tx_valid/tx_data activity while busy must not disturb 0x3C or queue 0x81.
        send(8'h3C, 9);
        repeat (10) begin
            step();
            check_idle("no_extra");
        end

        // Reset mid-frame, with tx_valid also high during reset.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (14) begin
            check("mid_line", tx_line, 1'b0);
            check("mid_busy", busy, 1'b1);
            step();
        end
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        step();
        check_idle("rst_abort");
        step();
        check_idle("rst_with_valid");
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (3) begin
            step();
            check_idle("post_rst");
        end
        send(8'h5A, -1);

`ifdef SERIAL_TX_PARITY_EN
        // Parity slot 0 for 0xA5, 1 for 0x07; frame is 44 cycles.
        send(8'hA5, -1);
        send(8'h07, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- UART-style serial transmitter. It is the driving end of a single-bit serial line that a registered sampler (clk/d/q style flop stage) captures on the far side.
- Accepts one parallel word per valid/ready handshake and shifts it out LSB-first as a framed bit stream: start bit, data bits, optional parity bit, stop bit.
- Each bit is held for a fixed number of clk cycles.

Parameters:
- DATA_W, 8, data bits per frame (>=1)
- CLKS_PER_BIT, 4, clk cycles each line bit is held (>=1; 1 is legal)

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  DATA_W  word to send; sampled only on the accept edge
- tx_valid  input  1  producer has a word on tx_data
- tx_ready  output  1  transmitter idle and able to accept; 1 exactly when state==IDLE
- tx_line  output  1  registered serial output; idle level 1
- busy  output  1  frame in progress; equals ~tx_ready

Behaviour:
- Reset (rst sampled 1 at an edge):
  - state=IDLE; tx_line=1, tx_ready=1, busy=0.
  - Bit counter, cycle counter and shift register are cleared.
  - Reset mid-frame aborts the frame: tx_line is 1 from the reset edge on, and no partial resume occurs.
- Accept: at an edge with tx_valid=1 and tx_ready=1, tx_data is latched into the shift register and state moves to START.
  - tx_valid while busy is ignored: no queuing, no effect.
  - tx_data changes after the accept edge do not affect the frame in flight.
- States:
  - IDLE -> START on accept.
  - START: tx_line=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: bit i (i=0..DATA_W-1, LSB first) held CLKS_PER_BIT cycles each; after bit DATA_W-1 -> PARITY if enabled, else STOP.
  - PARITY (feature only): one bit, CLKS_PER_BIT cycles -> STOP.
  - STOP: tx_line=1 for CLKS_PER_BIT cycles -> IDLE.
- Timing, with accept edge at cycle T and N = total frame bits:
  - tx_line falls at cycle T+1.
  - Line bit k occupies cycles T+1+k*CLKS_PER_BIT through T+(k+1)*CLKS_PER_BIT.
  - tx_ready returns to 1 at cycle T+1+N*CLKS_PER_BIT.
- Back-to-back: with tx_valid held high, the next accept happens on the edge where tx_ready is 1. The next start bit begins the following cycle, so the minimum frame period is N*CLKS_PER_BIT+1 cycles, with one idle-high cycle between frames.
- Counters:
  - Cycle counter width is $clog2(CLKS_PER_BIT), minimum 1. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on bit advance.
  - Bit index width is $clog2(DATA_W+1). Neither counter ever exceeds its terminal value.
- Simultaneous rst and tx_valid: reset wins; the word is not accepted.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: an even parity bit (XOR-reduction of the latched word) is inserted between the last data bit and stop. N = DATA_W+3.
- Undefined: PARITY state and logic are absent. N = DATA_W+2.

Decomposition:
- Shared package serial_pkg holds:
  - State encoding constants: IDLE, START, DATA, PARITY, STOP, in a 3-bit state type.
  - LINE_IDLE=1 and START_BIT=0.
  - The frame-length function N(DATA_W), gated by SERIAL_TX_PARITY_EN.
  - The future serial_rx reuses the same package.
- One sub-module, serial_baud_cnt:
  - Inputs: clk, rst, clear.
  - Output: bit_done, a single-cycle pulse on the last cycle of each bit.

Test Plan:
- Reset then idle (DATA_W=8, CLKS_PER_BIT=4): hold rst 3 cycles, release, keep tx_valid=0 for 20 cycles -> tx_line=1, tx_ready=1, busy=0 throughout.
- Single frame: accept 0xA5 at cycle T.
  - tx_line per 4-cycle slot = 0, 1,0,1,0,0,1,0,1, 1 (start, data LSB-first, stop), starting at T+1.
  - tx_ready=0 from T+1 to T+40; tx_ready=1 at T+41.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> second start bit begins at T+42. Line is all-0 data for frame 1 and all-1 data for frame 2, with one idle cycle between frames.
- Ignore while busy: during frame 0x3C, pulse tx_valid with 0x81 at T+10 and change tx_data -> frame still carries 0x3C; no extra frame follows.
- Reset mid-frame: assert rst at T+15 of a 0x00 frame -> tx_line=1 from that edge. tx_ready=1 after release. A new 0x5A frame then transmits correctly.
- With SERIAL_TX_PARITY_EN, send 0xA5 then 0x07:
  - Parity slot is 0 for 0xA5 and 1 for 0x07.
  - Frame is 44 cycles; tx_ready returns at T+45.
